mcast_replicator: RTL and testbench

MCAST_REPLICATOR -- requirements
Module: mcast_replicator

---
 rtl/mcast_replicator.sv | 222 ++++++++++++++++++++++
 tb/tb_mcast_replicator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcast_replicator.sv
// ============================================================================
//  Module   : mcast_replicator
//  Purpose  : Multicast/broadcast replicator that expands a packet into
//             unicast copies and skips the faulty node.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcast_replicator #(
    parameter logic [2:0] LOCAL_X = 3'd0,
    parameter logic [2:0] LOCAL_Y = 3'd0,
    parameter int         DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_tgt_x,
    input  logic [2:0]        in_tgt_y,
    input  logic [2:0]        in_src_x,
    input  logic [2:0]        in_src_y,
    input  logic [1:0]        in_pkt_type,
    input  logic [DATA_W-1:0] in_payload,
    input  logic              pg_en,
    input  logic [2:0]        pg_node_x,
    input  logic [2:0]        pg_node_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_tgt_x,
    output logic [2:0]        out_tgt_y,
    output logic [2:0]        out_src_x,
    output logic [2:0]        out_src_y,
    output logic [1:0]        out_pkt_type,
    output logic [DATA_W-1:0] out_payload,
    output logic              busy,
    output logic              repl_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_REPL = 2'd2
    } state_t;

    // Copy index space: y for column, x for row, {y,x} for broadcast.
    // Returns {hit, skip_index}.
    function automatic logic [6:0] skip_of(input logic [1:0] pt, input logic [2:0] tx,
                                           input logic [2:0] ty, input logic [2:0] px,
                                           input logic [2:0] py);
        case (pt)
            2'b01:   skip_of = {px == tx, 3'd0, py};
            2'b10:   skip_of = {py == ty, 3'd0, px};
            2'b11:   skip_of = {1'b1, py, px};
            default: skip_of = 7'd0;
        endcase
    endfunction

    function automatic logic [5:0] max_of(input logic [1:0] pt);
        max_of = (pt == 2'b11) ? 6'd63 : 6'd7;
    endfunction

    // Returns the copy target as {y, x}.
    function automatic logic [5:0] copy_tgt(input logic [1:0] pt, input logic [2:0] tx,
                                            input logic [2:0] ty, input logic [5:0] idx);
        case (pt)
            2'b01:   copy_tgt = {idx[2:0], tx};
            2'b10:   copy_tgt = {ty, idx[2:0]};
            default: copy_tgt = idx;
        endcase
    endfunction

    state_t            r_state, w_nxt_state;
    logic [5:0]        r_idx, w_nxt_idx;
    logic [1:0]        r_type, w_nxt_type;
    logic [2:0]        r_tgt_x, r_tgt_y, r_pg_x, r_pg_y;
    logic [2:0]        w_nxt_tgt_x, w_nxt_tgt_y, w_nxt_pg_x, w_nxt_pg_y;
    logic              r_out_valid, w_nxt_out_valid;
    logic [2:0]        r_out_tgt_x, r_out_tgt_y, r_out_src_x, r_out_src_y;
    logic [2:0]        w_nxt_out_tgt_x, w_nxt_out_tgt_y, w_nxt_out_src_x, w_nxt_out_src_y;
    logic [1:0]        r_out_type, w_nxt_out_type;
    logic [DATA_W-1:0] r_out_payload, w_nxt_out_payload;
    logic              r_busy, w_nxt_busy, r_repl_done, w_nxt_repl_done;

    logic [6:0] w_in_skip, w_r_skip;
    logic [5:0] w_in_first, w_r_max, w_r_last, w_inc_idx, w_adv_idx;
    logic       w_accept, w_emit, w_last;

    always_comb begin
        w_in_skip  = skip_of(in_pkt_type, in_tgt_x, in_tgt_y, pg_node_x, pg_node_y);
        w_in_first = (w_in_skip[6] && (w_in_skip[5:0] == 6'd0)) ? 6'd1 : 6'd0;
        w_r_skip   = skip_of(r_type, r_tgt_x, r_tgt_y, r_pg_x, r_pg_y);
        w_r_max    = max_of(r_type);
        w_r_last   = (w_r_skip[6] && (w_r_skip[5:0] == w_r_max)) ? w_r_max - 6'd1 : w_r_max;
        w_inc_idx  = r_idx + 6'd1;
        w_adv_idx  = (w_r_skip[6] && (w_inc_idx == w_r_skip[5:0])) ? r_idx + 6'd2 : w_inc_idx;
        w_last     = (r_idx == w_r_last);
        w_emit     = r_out_valid & out_ready;

        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_PASS:  in_ready = out_ready;
            S_REPL:  in_ready = w_last & out_ready;
            default: in_ready = 1'b0;
        endcase
        w_accept = in_valid & in_ready;
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_idx         = r_idx;
        w_nxt_type        = r_type;
        w_nxt_tgt_x       = r_tgt_x;
        w_nxt_tgt_y       = r_tgt_y;
        w_nxt_pg_x        = r_pg_x;
        w_nxt_pg_y        = r_pg_y;
        w_nxt_out_valid   = r_out_valid;
        w_nxt_out_tgt_x   = r_out_tgt_x;
        w_nxt_out_tgt_y   = r_out_tgt_y;
        w_nxt_out_src_x   = r_out_src_x;
        w_nxt_out_src_y   = r_out_src_y;
        w_nxt_out_type    = r_out_type;
        w_nxt_out_payload = r_out_payload;
        w_nxt_repl_done   = 1'b0;

        case (r_state)
            S_PASS: begin
                if (w_emit) begin
                    w_nxt_state     = S_IDLE;
                    w_nxt_out_valid = 1'b0;
                end
            end
            S_REPL: begin
                if (w_emit && w_last) begin
                    w_nxt_repl_done = 1'b1;
                    w_nxt_state     = S_IDLE;
                    w_nxt_out_valid = 1'b0;
                end else if (w_emit) begin
                    w_nxt_idx = w_adv_idx;
                    {w_nxt_out_tgt_y, w_nxt_out_tgt_x} = copy_tgt(r_type, r_tgt_x, r_tgt_y, w_adv_idx);
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        // A new packet may overwrite the output in the same cycle the old one leaves.
        if (w_accept) begin
            w_nxt_out_valid   = 1'b1;
            w_nxt_out_src_x   = in_src_x;
            w_nxt_out_src_y   = in_src_y;
            w_nxt_out_payload = in_payload;
            w_nxt_type        = in_pkt_type;
            w_nxt_tgt_x       = in_tgt_x;
            w_nxt_tgt_y       = in_tgt_y;
            w_nxt_pg_x        = pg_node_x;
            w_nxt_pg_y        = pg_node_y;
            if (pg_en && (in_pkt_type != 2'b00)) begin
                w_nxt_state    = S_REPL;
                w_nxt_idx      = w_in_first;
                w_nxt_out_type = 2'b00;
                {w_nxt_out_tgt_y, w_nxt_out_tgt_x} = copy_tgt(in_pkt_type, in_tgt_x, in_tgt_y, w_in_first);
            end else begin
                w_nxt_state     = S_PASS;
                w_nxt_idx       = 6'd0;
                w_nxt_out_type  = in_pkt_type;
                w_nxt_out_tgt_x = in_tgt_x;
                w_nxt_out_tgt_y = in_tgt_y;
            end
        end
        w_nxt_busy = (w_nxt_state == S_REPL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 6'd0;
            r_type        <= 2'b00;
            r_tgt_x       <= 3'd0;
            r_tgt_y       <= 3'd0;
            r_pg_x        <= 3'd0;
            r_pg_y        <= 3'd0;
            r_out_valid   <= 1'b0;
            r_out_tgt_x   <= 3'd0;
            r_out_tgt_y   <= 3'd0;
            r_out_src_x   <= 3'd0;
            r_out_src_y   <= 3'd0;
            r_out_type    <= 2'b00;
            r_out_payload <= '0;
            r_busy        <= 1'b0;
            r_repl_done   <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_idx         <= w_nxt_idx;
            r_type        <= w_nxt_type;
            r_tgt_x       <= w_nxt_tgt_x;
            r_tgt_y       <= w_nxt_tgt_y;
            r_pg_x        <= w_nxt_pg_x;
            r_pg_y        <= w_nxt_pg_y;
            r_out_valid   <= w_nxt_out_valid;
            r_out_tgt_x   <= w_nxt_out_tgt_x;
            r_out_tgt_y   <= w_nxt_out_tgt_y;
            r_out_src_x   <= w_nxt_out_src_x;
            r_out_src_y   <= w_nxt_out_src_y;
            r_out_type    <= w_nxt_out_type;
            r_out_payload <= w_nxt_out_payload;
            r_busy        <= w_nxt_busy;
            r_repl_done   <= w_nxt_repl_done;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_tgt_x    = r_out_tgt_x;
    assign out_tgt_y    = r_out_tgt_y;
    assign out_src_x    = r_out_src_x;
    assign out_src_y    = r_out_src_y;
    assign out_pkt_type = r_out_type;
    assign out_payload  = r_out_payload;
    assign busy         = r_busy;
    assign repl_done    = r_repl_done;

endmodule

`default_nettype wire

// File: tb/tb_mcast_replicator.sv
// ============================================================================
//  Module   : tb_mcast_replicator
//  Purpose  : Self-checking bench for mcast_replicator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcast_replicator;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [2:0]    in_tgt_x, in_tgt_y, in_src_x, in_src_y;
    logic [1:0]    in_pkt_type;
    logic [DW-1:0] in_payload;
    logic          pg_en;
    logic [2:0]    pg_node_x, pg_node_y;
    logic          out_valid, out_ready;
    logic [2:0]    out_tgt_x, out_tgt_y, out_src_x, out_src_y;
    logic [1:0]    out_pkt_type;
    logic [DW-1:0] out_payload;
    logic          busy, repl_done;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] got_q[$];

    mcast_replicator #(.LOCAL_X(3'd0), .LOCAL_Y(3'd0), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tgt_x(in_tgt_x), .in_tgt_y(in_tgt_y),
        .in_src_x(in_src_x), .in_src_y(in_src_y),
        .in_pkt_type(in_pkt_type), .in_payload(in_payload),
        .pg_en(pg_en), .pg_node_x(pg_node_x), .pg_node_y(pg_node_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tgt_x(out_tgt_x), .out_tgt_y(out_tgt_y),
        .out_src_x(out_src_x), .out_src_y(out_src_y),
        .out_pkt_type(out_pkt_type), .out_payload(out_payload),
        .busy(busy), .repl_done(repl_done)
    );

    always #5 clk = ~clk;

    // Packet image: tgt_x[45:43] tgt_y[42:40] src_x[39:37] src_y[36:34] type[33:32] payload[31:0]
    function automatic logic [63:0] pack(input logic [2:0] tx, input logic [2:0] ty,
                                         input logic [2:0] sx, input logic [2:0] sy,
                                         input logic [1:0] pt, input logic [31:0] pl);
        return {18'd0, tx, ty, sx, sy, pt, pl};
    endfunction

    function automatic logic [63:0] dut_pkt();
        return pack(out_tgt_x, out_tgt_y, out_src_x, out_src_y, out_pkt_type, out_payload);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_pkt(input logic [1:0] pt, input logic [2:0] tx, input logic [2:0] ty,
                             input logic [2:0] sx, input logic [2:0] sy, input logic [31:0] pl);
        in_pkt_type = pt; in_tgt_x = tx; in_tgt_y = ty;
        in_src_x = sx; in_src_y = sy; in_payload = pl;
    endtask

    // Injects one packet from idle and collects every resulting output against
    // the list of expected copies built from the mesh rules.
    task automatic do_packet(input logic [1:0] pt, input logic [2:0] tx, input logic [2:0] ty,
                             input logic [2:0] sx, input logic [2:0] sy, input logic [31:0] pl,
                             input logic pen, input logic [2:0] px, input logic [2:0] py,
                             input int stall, input bit scramble);
        logic [63:0] exp_q[$];
        bit mc, in_set;
        int k, n, cyc;
        mc = pen && (pt != 2'b00);
        got_q.delete();
        if (!mc) exp_q.push_back(pack(tx, ty, sx, sy, pt, pl));
        else begin
            for (int y = 0; y < 8; y++) begin
                for (int x = 0; x < 8; x++) begin
                    in_set = (pt == 2'b01) ? (3'(x) == tx) : (pt == 2'b10) ? (3'(y) == ty) : 1'b1;
                    if (in_set && !(3'(x) == px && 3'(y) == py))
                        exp_q.push_back(pack(3'(x), 3'(y), sx, sy, 2'b00, pl));
                end
            end
        end
        n = exp_q.size();
        @(negedge clk);
        drive_pkt(pt, tx, ty, sx, sy, pl);
        in_valid = 1'b1; out_ready = 1'b1;
        pg_en = pen; pg_node_x = px; pg_node_y = py;
        #1 check("inject_ready", in_ready, 1'b1);
        k = 0; cyc = 0;
        while (k < n && cyc < 2000) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (scramble) begin
                pg_en = 1'($urandom_range(1));
                pg_node_x = 3'($urandom_range(7));
                pg_node_y = 3'($urandom_range(7));
            end
            out_ready = ($urandom_range(99) >= stall);
            #1;
            check("out_valid", out_valid, 1'b1);
            if (out_valid) begin
                check("copy", dut_pkt(), exp_q[k]);
                check("in_ready", in_ready, (k == n - 1) && out_ready);
                check("busy", busy, mc);
                check("done_early", repl_done, 1'b0);
                if (out_ready) begin
                    got_q.push_back(dut_pkt());
                    k++;
                end
            end
            cyc++;
        end
        if (k < n) begin
            n_vec++; n_err++;
            $display("FAIL timeout: got %0d copies expected %0d", k, n);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("valid_after", out_valid, 1'b0);
        check("done_pulse", repl_done, mc);
        check("busy_after", busy, 1'b0);
        @(negedge clk);
        #1 check("done_once", repl_done, 1'b0);
    endtask

    typedef struct {
        logic [1:0] pt;
        logic [2:0] tx, ty, sx, sy;
        logic       pen;
        logic [2:0] px, py;
        int         exp_n;
        logic [2:0] fx, fy, lx, ly;
    } vec_t;

    vec_t tbl[9];
    logic [63:0] pkt_prev, pkt_u;
    logic [31:0] pl;

    initial begin
        tbl[0] = '{2'b00, 3'd5, 3'd2, 3'd1, 3'd1, 1'b0, 3'd0, 3'd0, 1,  3'd5, 3'd2, 3'd5, 3'd2};
        tbl[1] = '{2'b01, 3'd3, 3'd0, 3'd3, 3'd0, 1'b1, 3'd3, 3'd4, 7,  3'd3, 3'd0, 3'd3, 3'd7};
        tbl[2] = '{2'b10, 3'd0, 3'd1, 3'd4, 3'd4, 1'b1, 3'd7, 3'd1, 7,  3'd0, 3'd1, 3'd6, 3'd1};
        tbl[3] = '{2'b10, 3'd0, 3'd1, 3'd4, 3'd4, 1'b1, 3'd2, 3'd5, 8,  3'd0, 3'd1, 3'd7, 3'd1};
        tbl[4] = '{2'b11, 3'd0, 3'd0, 3'd2, 3'd3, 1'b1, 3'd0, 3'd0, 63, 3'd1, 3'd0, 3'd7, 3'd7};
        tbl[5] = '{2'b11, 3'd0, 3'd0, 3'd2, 3'd3, 1'b1, 3'd7, 3'd7, 63, 3'd0, 3'd0, 3'd6, 3'd7};
        tbl[6] = '{2'b01, 3'd2, 3'd0, 3'd5, 3'd5, 1'b1, 3'd2, 3'd0, 7,  3'd2, 3'd1, 3'd2, 3'd7};
        tbl[7] = '{2'b01, 3'd4, 3'd6, 3'd0, 3'd7, 1'b0, 3'd4, 3'd3, 1,  3'd4, 3'd6, 3'd4, 3'd6};
        tbl[8] = '{2'b00, 3'd7, 3'd7, 3'd0, 3'd1, 1'b1, 3'd7, 3'd7, 1,  3'd7, 3'd7, 3'd7, 3'd7};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pg_en = 1'b0;
        pg_node_x = 3'd0; pg_node_y = 3'd0;
        drive_pkt(2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", repl_done, 1'b0);
        check("rst_fields", dut_pkt(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back unicast injections, one output per cycle.
        pg_en = 1'b0; out_ready = 1'b1;
        pkt_prev = 64'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pl = 32'hA000_0000 + 32'(i);
            drive_pkt(2'b00, 3'd5, 3'd2, 3'(i), 3'd1, pl);
            in_valid = 1'b1;
            #1;
            check("b2b_ready", in_ready, 1'b1);
            if (i > 0) begin
                check("b2b_valid", out_valid, 1'b1);
                check("b2b_pkt", dut_pkt(), pkt_prev);
            end
            pkt_prev = pack(3'd5, 3'd2, 3'(i), 3'd1, 2'b00, pl);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("b2b_last", dut_pkt(), pkt_prev);
        @(negedge clk);
        #1 check("b2b_drain", out_valid, 1'b0);

        // Table-driven vectors with count, first and last copy.
        foreach (tbl[i]) begin
            do_packet(tbl[i].pt, tbl[i].tx, tbl[i].ty, tbl[i].sx, tbl[i].sy,
                      32'hC0DE_0000 + 32'(i), tbl[i].pen, tbl[i].px, tbl[i].py, 0, 1'b0);
            check("tbl_count", 64'(got_q.size()), 64'(tbl[i].exp_n));
            if (got_q.size() > 0) begin
                check("tbl_first", {got_q[0][45:43], got_q[0][42:40]}, {tbl[i].fx, tbl[i].fy});
                check("tbl_last", {got_q[$][45:43], got_q[$][42:40]}, {tbl[i].lx, tbl[i].ly});
            end
        end

        // Accept of the next packet on the same cycle as the last copy leaves.
        @(negedge clk);
        drive_pkt(2'b01, 3'd6, 3'd0, 3'd1, 3'd2, 32'h1234_5678);
        pg_en = 1'b1; pg_node_x = 3'd6; pg_node_y = 3'd6;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        drive_pkt(2'b00, 3'd2, 3'd3, 3'd4, 3'd5, 32'h0BAD_F00D);
        pg_en = 1'b0;
        pkt_u = pack(3'd2, 3'd3, 3'd4, 3'd5, 2'b00, 32'h0BAD_F00D);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check("ovl_copy", dut_pkt(),
                  pack(3'd6, (c < 6) ? 3'(c) : 3'd7, 3'd1, 3'd2, 2'b00, 32'h1234_5678));
            check("ovl_ready", in_ready, c == 6);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("ovl_next", dut_pkt(), pkt_u);
        check("ovl_valid", out_valid, 1'b1);
        check("ovl_done", repl_done, 1'b1);
        check("ovl_busy", busy, 1'b0);
        @(negedge clk);
        #1;
        check("ovl_drain", out_valid, 1'b0);
        check("ovl_done_once", repl_done, 1'b0);

        // Reset asserted mid-broadcast after the third copy.
        @(negedge clk);
        drive_pkt(2'b11, 3'd0, 3'd0, 3'd1, 3'd1, 32'h5555_AAAA);
        pg_en = 1'b1; pg_node_x = 3'd0; pg_node_y = 3'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("pre_rst_copy", dut_pkt(), pack(3'd4, 3'd0, 3'd1, 3'd1, 2'b00, 32'h5555_AAAA));
        #1 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("post_rst_quiet", {out_valid, busy}, 2'b00);
        end
        do_packet(2'b00, 3'd1, 3'd6, 3'd3, 3'd3, 32'hFEED_0001, 1'b0, 3'd0, 3'd0, 0, 1'b0);
        check("post_rst_count", 64'(got_q.size()), 64'd1);

        // Random packets with stalls and fault-node churn after accept.
        for (int r = 0; r < 40; r++) begin
            do_packet(2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                      3'($urandom_range(7)), 3'($urandom_range(7)), $urandom,
                      ($urandom_range(3) != 0), 3'($urandom_range(7)), 3'($urandom_range(7)),
                      40, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
